// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LD_STALL = 2'd1,
    HZ_MC_WAIT  = 2'd2
  } hz_state_e;

  localparam int FWD_NONE   = 0;
  localparam int REG_ADDR_W = 5;

  // x0 is hard-wired zero, so it never matches for forwarding or hazards.
  function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/fwd_sel_one.sv
// One EX source against NUM_STAGES downstream stages; nearest writing stage wins.
// Purely combinational, no backpressure.
module fwd_sel_one
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_ADDR_W-1:0]            rs_addr,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] stg_rd_addr,
  input  logic [NUM_STAGES-1:0]            stg_rd_wren,
  output logic [SEL_W-1:0]                 sel
);

  // Scan farthest to nearest so the nearest match is the last assignment.
  always_comb begin
    sel = SEL_W'(FWD_NONE);
    for (int s = NUM_STAGES; s >= 1; s--) begin
      if (stg_rd_wren[s-1] &&
          addr_hit(stg_rd_addr[(s-1)*REG_ADDR_W +: REG_ADDR_W], rs_addr)) begin
        sel = SEL_W'(s);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forward selects, load-use and multi-cycle scoreboard stall; HAZARD_PERF_EN adds stall counters.
// Selects and o_stall are combinational; o_stall is the backpressure driven into IF/ID.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int NUM_STAGES = 2,
  localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    i_ex_rs_addr,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] i_stg_rd_addr,
  input  logic [NUM_STAGES-1:0]            i_stg_rd_wren,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]    i_id_rs_addr,
  input  logic [NUM_SRC-1:0]               i_id_rs_used,
  input  logic [REG_ADDR_W-1:0]            i_ex_rd_addr,
  input  logic                             i_ex_is_load,
  input  logic                             i_mc_issue,
  input  logic [REG_ADDR_W-1:0]            i_mc_rd_addr,
  input  logic                             i_mc_done,
`ifdef HAZARD_PERF_EN
  output logic [31:0]                      o_stall_cycles,
  output logic [15:0]                      o_ld_stall_cnt,
`endif
  output logic [NUM_SRC*SEL_W-1:0]         o_fwd_sel,
  output logic                             o_stall,
  output logic                             o_mc_busy
);

  logic [31:0]     pending;
  logic [31:0]     pending_n;
  logic [REG_ADDR_W-1:0] mc_rd_q;
  logic            mc_clr;
  logic            mc_set;
  logic            ld_haz;
  logic            pend_hit;
  logic            mc_haz;
  hz_state_e       state;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_sel_one #(
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W)
    ) u_fwd_sel (
      .rs_addr     (i_ex_rs_addr[k*REG_ADDR_W +: REG_ADDR_W]),
      .stg_rd_addr (i_stg_rd_addr),
      .stg_rd_wren (i_stg_rd_wren),
      .sel         (o_fwd_sel[k*SEL_W +: SEL_W])
    );
  end

  always_comb begin
    ld_haz   = 1'b0;
    pend_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_id_rs_used[k]) begin
        if (addr_hit(i_id_rs_addr[k*REG_ADDR_W +: REG_ADDR_W], i_ex_rd_addr)) begin
          ld_haz = i_ex_is_load;
        end
        if (pending[i_id_rs_addr[k*REG_ADDR_W +: REG_ADDR_W]]) begin
          pend_hit = 1'b1;
        end
      end
    end
  end

  assign o_mc_busy = (pending != '0);
  assign mc_haz    = pend_hit || (i_mc_issue && o_mc_busy);
  assign o_stall   = ld_haz || mc_haz;

  // A done retiring the only entry frees the slot for an issue in the same cycle.
  assign mc_clr = i_mc_done && o_mc_busy;
  assign mc_set = i_mc_issue && (!o_mc_busy || mc_clr);

  always_comb begin
    pending_n = pending;
    if (mc_clr) begin
      pending_n[mc_rd_q] = 1'b0;
    end
    if (mc_set) begin
      pending_n[i_mc_rd_addr] = 1'b1;
    end
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending <= '0;
      mc_rd_q <= '0;
    end else begin
      pending <= pending_n;
      if (mc_set) begin
        mc_rd_q <= i_mc_rd_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= HZ_RUN;
    end else begin
      case (state)
        HZ_RUN: begin
          if (ld_haz) begin
            state <= HZ_LD_STALL;
          end else if (mc_haz) begin
            state <= HZ_MC_WAIT;
          end
        end
        HZ_LD_STALL: state <= HZ_RUN;
        HZ_MC_WAIT: begin
          if (i_mc_done) begin
            state <= HZ_RUN;
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_ld_stall_cnt <= '0;
    end else begin
      if (o_stall && (o_stall_cycles != 32'hFFFF_FFFF)) begin
        o_stall_cycles <= o_stall_cycles + 32'd1;
      end
      if ((state == HZ_RUN) && ld_haz && (o_ld_stall_cnt != 16'hFFFF)) begin
        o_ld_stall_cnt <= o_ld_stall_cnt + 16'd1;
      end
    end
  end
`endif

  // Only one multi-cycle op may be outstanding; a second issue is dropped.
  a_issue_while_busy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_mc_issue && o_mc_busy && !i_mc_done));

  a_ld_stall_one_cycle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state == HZ_LD_STALL) |=> (state == HZ_RUN));

  a_pending_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(pending) && !pending[0]);

endmodule
